// File: rtl/div_ratio_pkg.sv
// rtl/div_ratio_pkg.sv - shared types and helpers for the divider-ratio detector
package div_ratio_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_e;

    localparam logic [1:0] DIV2  = 2'd0;
    localparam logic [1:0] DIV4  = 2'd1;
    localparam logic [1:0] DIV8  = 2'd2;
    localparam logic [1:0] DIV16 = 2'd3;

    typedef struct packed {
        logic       valid;
        logic [1:0] code;
    } ratio_code_t;

    function automatic ratio_code_t period_to_code(input logic [31:0] p);
        ratio_code_t r;
        r.valid = 1'b1;
        r.code  = DIV2;
        case (p)
            32'd2:   r.code = DIV2;
            32'd4:   r.code = DIV4;
            32'd8:   r.code = DIV8;
            32'd16:  r.code = DIV16;
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sync_rise_det.sv
// rtl/sync_rise_det.sv - two-flop synchronizer with rising-edge pulse for an async clock tap
module sync_rise_det (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic rise
);

    logic meta_q;
    logic sync_q;
    logic dly_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            dly_q  <= 1'b0;
        end else begin
            meta_q <= sig_in;
            sync_q <= meta_q;
            dly_q  <= sync_q;
        end
    end

    assign rise = sync_q & ~dly_q;

endmodule

// File: rtl/div_ratio_detector.sv
// rtl/div_ratio_detector.sv - measures an async divided clock's period and locks onto /2,/4,/8,/16
module div_ratio_detector
    import div_ratio_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 4,
    parameter int TIMEOUT  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             clear,
    output logic             locked,
    output logic [4:0]       ratio,
    output logic [1:0]       code,
    output logic             err,
    output logic [CNT_W-1:0] period
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [3:0]       LOCK_C    = 4'(LOCK_CNT);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [4:0]       cand_q, cand_d;
    logic [4:0]       ratio_q, ratio_d;
    logic [3:0]       match_q, match_d;
    logic [3:0]       match_inc;
    logic [1:0]       code_q, code_d;
    logic             err_q, err_d;
    logic             rise;
    logic             p_is_cand;
    logic             p_is_ratio;
    logic             timed_out;
    ratio_code_t      pc;

    sync_rise_det u_sync (
        .clk    (clk),
        .rst    (rst),
        .sig_in (sig_in),
        .rise   (rise)
    );

    // The counter is loaded with 1 on each rise, so at the next rise it holds the spacing.
    assign pc         = period_to_code(32'(cnt_q));
    assign p_is_cand  = (cnt_q == CNT_W'(cand_q));
    assign p_is_ratio = (cnt_q == CNT_W'(ratio_q));
    assign match_inc  = p_is_cand ? match_q + 4'd1 : 4'd1;
    assign timed_out  = (cnt_q >= TIMEOUT_C);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) state_d = MEASURE;
                end
                MEASURE: begin
                    if (rise) begin
                        if (pc.valid && (match_inc >= LOCK_C)) state_d = LOCKED;
                    end else if (timed_out) begin
                        state_d = IDLE;
                    end
                end
                LOCKED: begin
                    if (rise) begin
                        if (!p_is_ratio) state_d = MEASURE;
                    end else if (timed_out) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        period_d = period_q;
        cand_d   = cand_q;
        match_d  = match_q;
        ratio_d  = ratio_q;
        code_d   = code_q;
        err_d    = err_q;
        if (rise) cnt_d = CNT_W'(1);
        if (state_d != LOCKED) begin
            ratio_d = '0;
            code_d  = '0;
        end
        if (clear) begin
            cnt_d    = '0;
            period_d = '0;
            cand_d   = '0;
            match_d  = '0;
            err_d    = 1'b0;
        end else if (rise) begin
            if (state_q == IDLE) begin
                cand_d  = '0;
                match_d = '0;
            end else begin
                period_d = cnt_q;
                if ((state_q == MEASURE) || !p_is_ratio) begin
                    if (pc.valid) begin
                        cand_d  = cnt_q[4:0];
                        match_d = (state_q == MEASURE) ? match_inc : 4'd1;
                        if (state_d == LOCKED) begin
                            ratio_d = cnt_q[4:0];
                            code_d  = pc.code;
                        end
                    end else begin
                        err_d   = 1'b1;
                        cand_d  = '0;
                        match_d = '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            period_q <= '0;
            cand_q   <= '0;
            match_q  <= '0;
            ratio_q  <= '0;
            code_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
            cand_q   <= cand_d;
            match_q  <= match_d;
            ratio_q  <= ratio_d;
            code_q   <= code_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        locked = (state_q == LOCKED);
        ratio  = ratio_q;
        code   = code_q;
        err    = err_q;
        period = period_q;
    end

endmodule

// File: tb/tb_div_ratio_detector.sv
// tb/tb_div_ratio_detector.sv - self-checking bench for div_ratio_detector
module tb_div_ratio_detector;

    localparam int CNT_W    = 8;
    localparam int LOCK_CNT = 4;
    localparam int TIMEOUT  = 64;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sig_in = 1'b0;
    logic             clear = 1'b0;
    logic             locked;
    logic [4:0]       ratio;
    logic [1:0]       code;
    logic             err;
    logic [CNT_W-1:0] period;

    div_ratio_detector #(.CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT), .TIMEOUT(TIMEOUT)) dut (
        .clk    (clk),
        .rst    (rst),
        .sig_in (sig_in),
        .clear  (clear),
        .locked (locked),
        .ratio  (ratio),
        .code   (code),
        .err    (err),
        .period (period)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: tracks rise times and the run of identical valid periods.
    int cyc = 0;
    bit h1, h2, h3;
    bit armed;
    int last_rise;
    int run;
    int prevp;
    int m_period;
    bit m_err;

    typedef struct {
        int d;
        int n;
        int e_locked;
        int e_ratio;
        int e_code;
        int e_err;
        int e_period;
    } vec_t;

    vec_t tbl[7];

    function automatic int code_of(input int p);
        case (p)
            2:       return 0;
            4:       return 1;
            8:       return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_reset();
        h1 = 0; h2 = 0; h3 = 0;
        armed = 0; run = 0; prevp = 0; m_period = 0; m_err = 0; last_rise = 0;
    endtask

    task automatic model_edge(input logic s, input logic clr);
        bit r;
        int p;
        cyc++;
        r = h2 && !h3;
        h3 = h2; h2 = h1; h1 = s;
        if (clr) begin
            armed = 0; run = 0; prevp = 0; m_period = 0; m_err = 0;
        end else if (r) begin
            if (!armed) begin
                armed = 1; run = 0; prevp = 0;
            end else begin
                p = cyc - last_rise;
                m_period = p;
                if (!(p == 2 || p == 4 || p == 8 || p == 16)) begin
                    m_err = 1; run = 0; prevp = 0;
                end else if (p == prevp) begin
                    run++;
                end else begin
                    run = 1; prevp = p;
                end
            end
            last_rise = cyc;
        end else if (armed && (cyc - last_rise) >= TIMEOUT) begin
            armed = 0; run = 0;
        end
    endtask

    task automatic check_model();
        int el, er, ec;
        el = (armed && run >= LOCK_CNT) ? 1 : 0;
        er = el ? prevp : 0;
        ec = el ? code_of(prevp) : 0;
        n_total++;
        if ({locked, ratio, code, err, period} === {el[0], er[4:0], ec[1:0], m_err, m_period[7:0]})
            n_pass++;
        else
            $display("FAIL model cyc=%0d: got locked=%0d ratio=%0d code=%0d err=%0d period=%0d, expected locked=%0d ratio=%0d code=%0d err=%0d period=%0d",
                     cyc, locked, ratio, code, err, period, el, er, ec, m_err, m_period);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic chk_out(input string nm, input int l, input int r, input int c, input int e, input int p);
        chk({nm, ".locked"}, int'(locked), l);
        chk({nm, ".ratio"},  int'(ratio),  r);
        chk({nm, ".code"},   int'(code),   c);
        chk({nm, ".err"},    int'(err),    e);
        chk({nm, ".period"}, int'(period), p);
    endtask

    task automatic step(input logic s, input logic clr);
        @(negedge clk);
        sig_in = s;
        clear  = clr;
        @(posedge clk);
        model_edge(s, clr);
        #1;
        check_model();
    endtask

    task automatic lows(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 1'b0);
    endtask

    task automatic wave_duty(input int d, input int hi, input int n);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < hi; i++) step(1'b1, 1'b0);
            for (int i = hi; i < d; i++) step(1'b0, 1'b0);
        end
    endtask

    task automatic wave(input int d, input int n);
        wave_duty(d, d / 2, n);
    endtask

    task automatic restart();
        step(1'b0, 1'b1);
        lows(3);
    endtask

    initial begin
        int d, r;
        int dlist[13];
        dlist = '{2, 4, 8, 16, 2, 4, 8, 16, 3, 5, 6, 7, 12};

        tbl[0] = '{4,  5, 1, 4,  1, 0, 4};
        tbl[1] = '{4,  4, 0, 0,  0, 0, 4};
        tbl[2] = '{16, 6, 1, 16, 3, 0, 16};
        tbl[3] = '{2,  5, 1, 2,  0, 0, 2};
        tbl[4] = '{6,  5, 0, 0,  0, 1, 6};
        tbl[5] = '{8,  1, 0, 0,  0, 0, 0};
        tbl[6] = '{8,  5, 1, 8,  2, 0, 8};

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_out("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            restart();
            wave(tbl[i].d, tbl[i].n);
            lows(3);
            chk_out($sformatf("tbl%0d", i), tbl[i].e_locked, tbl[i].e_ratio,
                    tbl[i].e_code, tbl[i].e_err, tbl[i].e_period);
        end

        // /16 lock, then switch to /8
        restart();
        wave(16, 6);
        chk_out("div16_lock", 1, 16, 3, 0, 16);
        wave(8, 2);
        chk_out("div8_drop", 0, 0, 0, 0, 8);
        wave(8, 2);
        chk("div8_match3.locked", int'(locked), 0);
        wave(8, 1);
        chk_out("div8_relock", 1, 8, 2, 0, 8);

        // invalid spacing then /2 lock keeps err; clear drops it
        restart();
        wave(6, 3);
        chk_out("bad6", 0, 0, 0, 1, 6);
        wave(2, 6);
        chk_out("div2_err", 1, 2, 0, 1, 2);
        step(1'b0, 1'b1);
        chk_out("clear", 0, 0, 0, 0, 0);

        // timeout after a /8 lock
        restart();
        wave(8, 5);
        lows(58);
        chk_out("pre_timeout", 1, 8, 2, 0, 8);
        step(1'b0, 1'b0);
        chk_out("timeout", 0, 0, 0, 0, 8);
        wave(8, 1);
        lows(3);
        chk_out("rearm", 0, 0, 0, 0, 8);

        // async reset between edges while locked
        restart();
        wave(4, 5);
        chk_out("pre_rst", 1, 4, 1, 0, 4);
        #2;
        rst = 1'b1;
        #1;
        chk_out("async_rst", 0, 0, 0, 0, 0);
        model_reset();
        #1;
        rst = 1'b0;
        lows(3);
        wave(4, 4);
        chk("rst_relock_early.locked", int'(locked), 0);
        wave(4, 1);
        chk("rst_relock.locked", int'(locked), 1);

        // clear coincident with a rise at match=3
        restart();
        wave(4, 4);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        chk_out("clear_rise", 0, 0, 0, 0, 0);
        wave(4, 4);
        chk("clear_rise_early.locked", int'(locked), 0);
        wave(4, 1);
        chk("clear_rise_lock.locked", int'(locked), 1);

        // randomized traffic against the model
        for (int it = 0; it < 70; it++) begin
            r = $urandom_range(0, 11);
            if (r == 0) begin
                step(1'b0, 1'b1);
                lows($urandom_range(0, 4));
            end else if (r == 1) begin
                lows($urandom_range(60, 70));
            end else if (r == 2) begin
                for (int i = 0; i < 10; i++) step(1'($urandom_range(0, 1)), 1'b0);
            end else begin
                d = dlist[$urandom_range(0, 12)];
                wave_duty(d, $urandom_range(1, d - 1), $urandom_range(1, 7));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
